riscv_test_monitor: RTL and testbench

- Synthesizable end-of-test detector. Sits directly downstream of Core in the riscv-tests simulation flow and consumes its retire and register-writeback stream.
- Shadows gp (x3) and detects arrival at the pass/fail landing PC. Also detects timeout and self-loop hang.
- Presents a sticky verdict that the wrapping bench writes to result/<test>.txt.

---
 rtl/riscv_test_monitor_if.sv | 29 ++
 rtl/riscv_test_monitor.sv | 131 +++++++++++++
 tb/tb_riscv_test_monitor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_test_monitor_if.sv
// Retire / writeback / verdict bundle between the core-side stream and the
// end-of-test monitor.
//   master : drives start, retire_*, wb_*; observes the verdict outputs
//   slave  : the monitor; consumes the stream and drives done, passed,
//            status, fail_code, cycle_count, retire_count
interface riscv_test_monitor_if;
  logic        start;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        passed;
  logic [2:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  modport master (
    output start, retire_valid, retire_pc, wb_en, wb_addr, wb_data,
    input  done, passed, status, fail_code, cycle_count, retire_count
  );

  modport slave (
    input  start, retire_valid, retire_pc, wb_en, wb_addr, wb_data,
    output done, passed, status, fail_code, cycle_count, retire_count
  );
endinterface

// File: rtl/riscv_test_monitor.sv
// End-of-test detector for the riscv-tests flow. Shadows gp from the
// writeback stream, evaluates the verdict when the pass/fail landing PC
// retires, and also declares TIMEOUT (too many RUN cycles) or HANG (same PC
// retiring repeatedly). The verdict is sticky until rst.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : riscv_test_monitor_if.slave
//          in  start, retire_valid, retire_pc, wb_en, wb_addr, wb_data
//          out done, passed, status (0 IDLE,1 RUN,2 PASS,3 FAIL,4 TIMEOUT,
//              5 HANG), fail_code (gp[31:1] at FAIL), cycle_count,
//              retire_count
module riscv_test_monitor #(
  parameter logic [31:0] PASS_PC    = 32'h0000_0044,
  parameter int unsigned MAX_TICKS  = 5000,
  parameter int unsigned HANG_LIMIT = 16,
  parameter logic [4:0]  GP_IDX     = 5'd3
) (
  input logic                  clk,
  input logic                  rst,
  riscv_test_monitor_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HANG    = 3'd5
  } state_t;

  localparam logic [31:0] TIMEOUT_AT = 32'(MAX_TICKS - 1);
  localparam logic [31:0] HANG_AT    = 32'(HANG_LIMIT);

  state_t      state, state_next;
  logic [31:0] gp_shadow;
  logic [31:0] cycle_count, cycle_count_next;
  logic [31:0] retire_count, retire_count_next;
  logic [31:0] last_pc, last_pc_next;
  logic [31:0] hang_count, hang_count_next;
  logic [30:0] fail_code, fail_code_next;

  logic        gp_write;
  logic [31:0] eff_gp;
  logic        pass_hit;
  logic        other_retire;
  logic [31:0] hang_step;

  // x0 writes never reach the shadow, even if GP_IDX were overridden to 0.
  assign gp_write     = bus.wb_en && (bus.wb_addr == GP_IDX) && (bus.wb_addr != '0);
  assign eff_gp       = gp_write ? bus.wb_data : gp_shadow;
  assign pass_hit     = bus.retire_valid && (bus.retire_pc == PASS_PC);
  assign other_retire = bus.retire_valid && (bus.retire_pc != PASS_PC);
  assign hang_step    = (bus.retire_pc == last_pc) ? hang_count + 32'd1 : 32'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    cycle_count_next  = cycle_count;
    retire_count_next = retire_count;
    last_pc_next      = last_pc;
    hang_count_next   = hang_count;
    fail_code_next    = fail_code;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        // Counters include the cycle that produces the verdict.
        if (cycle_count != '1) cycle_count_next = cycle_count + 32'd1;
        if (bus.retire_valid && (retire_count != '1))
          retire_count_next = retire_count + 32'd1;

        if (pass_hit) begin
          if (eff_gp == 32'd1) begin
            state_next = PASS;
          end else begin
            state_next     = FAIL;
            fail_code_next = eff_gp[31:1];
          end
        end else begin
          if (other_retire) begin
            hang_count_next = hang_step;
            last_pc_next    = bus.retire_pc;
          end
          if (other_retire && (hang_step == HANG_AT))
            state_next = HANG;
          else if (cycle_count == TIMEOUT_AT)
            state_next = TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count  <= '0;
      retire_count <= '0;
      last_pc      <= '0;
      hang_count   <= '0;
      fail_code    <= '0;
    end else begin
      cycle_count  <= cycle_count_next;
      retire_count <= retire_count_next;
      last_pc      <= last_pc_next;
      hang_count   <= hang_count_next;
      fail_code    <= fail_code_next;
    end
  end

  // gp is tracked in every state so a late writeback is never lost.
  always_ff @(posedge clk) begin
    if (rst)           gp_shadow <= '0;
    else if (gp_write) gp_shadow <= bus.wb_data;
  end

  assign bus.status       = state;
  assign bus.done         = (state == PASS) || (state == FAIL) ||
                            (state == TIMEOUT) || (state == HANG);
  assign bus.passed       = (state == PASS);
  assign bus.fail_code    = fail_code;
  assign bus.cycle_count  = cycle_count;
  assign bus.retire_count = retire_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;
  localparam logic [31:0] PASS_PC    = 32'h0000_0044;
  localparam int          MAX_TICKS  = 5000;
  localparam int          HANG_LIMIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_test_monitor_if bus();

  riscv_test_monitor #(
    .PASS_PC(PASS_PC),
    .MAX_TICKS(MAX_TICKS),
    .HANG_LIMIT(HANG_LIMIT),
    .GP_IDX(5'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  string cur_tag = "reset";

  // Reference model: the verdict as a plain integer (0..5) plus counters.
  int          m_state;
  logic [31:0] m_gp, m_cyc, m_ret, m_last;
  logic [30:0] m_fc;
  int          m_hang;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%h expected=%h", cur_tag, tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit rv, input logic [31:0] pc,
                            input bit we, input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] gp_now;
    bit          final_tick;
    if (r) begin
      m_state = 0; m_gp = 0; m_cyc = 0; m_ret = 0; m_last = 0; m_fc = 0; m_hang = 0;
      return;
    end
    gp_now = (we && wa == 5'd3) ? wd : m_gp;
    if (we && wa == 5'd3) m_gp = wd;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1) begin
      final_tick = (m_cyc == 32'(MAX_TICKS - 1));
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (rv && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
      if (rv && pc == PASS_PC) begin
        if (gp_now == 1) m_state = 2;
        else begin m_state = 3; m_fc = gp_now[31:1]; end
      end else begin
        if (rv) begin
          m_hang = (pc == m_last) ? m_hang + 1 : 1;
          m_last = pc;
        end
        if (rv && m_hang == HANG_LIMIT) m_state = 5;
        else if (final_tick) m_state = 4;
      end
    end
  endtask

  task automatic check_all();
    chk("status", 32'(bus.status), 32'(m_state));
    chk("done", 32'(bus.done), 32'(m_state >= 2));
    chk("passed", 32'(bus.passed), 32'(m_state == 2));
    chk("fail_code", 32'(bus.fail_code), 32'(m_fc));
    chk("cycle_count", bus.cycle_count, m_cyc);
    chk("retire_count", bus.retire_count, m_ret);
  endtask

  task automatic tick(input bit r, input bit s, input bit rv, input logic [31:0] pc,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    rst              = r;
    bus.start        = s;
    bus.retire_valid = rv;
    bus.retire_pc    = pc;
    bus.wb_en        = we;
    bus.wb_addr      = wa;
    bus.wb_data      = wd;
    @(posedge clk);
    model_step(r, s, rv, pc, we, wa, wd);
    #1;
    check_all();
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go();
    tick(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic retire(input logic [31:0] pc);
    tick(0, 0, 1, pc, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] save_cyc, save_ret, pc, wd;
    logic [4:0]  wa;
    int n;

    // Reset state
    do_reset();
    chk("rst_status", 32'(bus.status), 32'd0);

    // Pass program
    cur_tag = "pass";
    go();
    for (int unsigned a = 0; a <= 32'h40; a += 4) begin
      if (a == 32'h3C) tick(0, 0, 1, a, 1, 5'd3, 32'd1);
      else retire(a);
    end
    retire(PASS_PC);
    chk("pass_status", 32'(bus.status), 32'd2);
    chk("pass_rcount", bus.retire_count, 32'd18);
    chk("pass_fcode", 32'(bus.fail_code), 32'd0);

    // Fail with bypass of a same-cycle gp write
    cur_tag = "fail_bypass";
    do_reset();
    tick(0, 0, 0, 0, 1, 5'd3, 32'd1);
    go();
    retire(32'h10);
    tick(0, 0, 1, PASS_PC, 1, 5'd3, 32'h0000_000B);
    chk("fb_status", 32'(bus.status), 32'd3);
    chk("fb_fcode", 32'(bus.fail_code), 32'd5);

    // Hang after HANG_LIMIT repeats with idle gaps
    cur_tag = "hang";
    do_reset();
    go();
    for (int i = 0; i < HANG_LIMIT; i++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) idle();
      retire(32'h100);
    end
    chk("hang_status", 32'(bus.status), 32'd5);

    cur_tag = "no_hang";
    do_reset();
    go();
    for (int i = 0; i < HANG_LIMIT - 1; i++) retire(32'h100);
    retire(32'h104);
    chk("nohang_status", 32'(bus.status), 32'd1);

    // Timeout with bounded wait
    cur_tag = "timeout";
    do_reset();
    go();
    n = 0;
    while (bus.done !== 1'b1 && n < MAX_TICKS + 100) begin idle(); n++; end
    chk("to_latency", 32'(n), 32'(MAX_TICKS));
    chk("to_status", 32'(bus.status), 32'd4);
    chk("to_cycles", bus.cycle_count, 32'd5000);

    // Verdict on the final cycle beats timeout
    cur_tag = "prio";
    do_reset();
    go();
    for (int i = 0; i < MAX_TICKS - 1; i++) idle();
    tick(0, 0, 1, PASS_PC, 1, 5'd3, 32'd1);
    chk("prio_status", 32'(bus.status), 32'd2);

    // x0 write ignored, then stickiness
    cur_tag = "x0";
    do_reset();
    tick(0, 0, 0, 0, 1, 5'd0, 32'd1);
    go();
    retire(PASS_PC);
    chk("x0_status", 32'(bus.status), 32'd3);
    chk("x0_fcode", 32'(bus.fail_code), 32'd0);
    save_cyc = bus.cycle_count;
    save_ret = bus.retire_count;
    tick(0, 1, 1, PASS_PC, 1, 5'd3, 32'd1);
    idle();
    chk("sticky_status", 32'(bus.status), 32'd3);
    chk("sticky_cyc", bus.cycle_count, save_cyc);
    chk("sticky_ret", bus.retire_count, save_ret);

    // Reset mid-run
    cur_tag = "midrst";
    do_reset();
    go();
    for (int i = 0; i < 200; i++) idle();
    chk("mr_cyc200", bus.cycle_count, 32'd200);
    do_reset();
    chk("mr_status", 32'(bus.status), 32'd0);
    chk("mr_cyc0", bus.cycle_count, 32'd0);
    go();
    for (int i = 0; i < 3; i++) idle();
    chk("mr_cyc3", bus.cycle_count, 32'd3);

    // Randomized traffic against the model
    cur_tag = "random";
    for (int run = 0; run < 10; run++) begin
      do_reset();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        tick(0, 0, $urandom_range(0, 1), $urandom, 1, 5'd3, $urandom_range(0, 2));
      go();
      pc = 32'h200;
      for (int c = 0; c < 400; c++) begin
        case ($urandom_range(0, 9))
          0:       pc = PASS_PC;
          1, 2:    pc = $urandom & 32'hFFFC;
          3:       pc = pc + 4;
          default: ;
        endcase
        case ($urandom_range(0, 3))
          0: wa = 5'd0;
          1: wa = 5'($urandom);
          default: wa = 5'd3;
        endcase
        wd = ($urandom_range(0, 2) == 0) ? $urandom : 32'd1;
        tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 5) == 0), wa, wd);
        if (pc == PASS_PC) pc = 32'h300;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
